// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with programmable wait states
// and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       lane_p0;
    logic [2:0]       size_p0;
    logic             write_p0;
    logic [31:0]      mem [MEM_DEPTH];

    logic ready_state;
    logic accept;
    logic legal;
    logic unused_ok;

    function automatic logic addr_legal(input logic [31:0] addr, input logic [2:0] size);
        logic in_range;
        logic aligned;
        in_range = ({2'b00, addr[31:2]} < 32'(MEM_DEPTH));
        case (size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~addr[0];
            3'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return in_range && aligned;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic [2:0] size);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lane;
            3'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] w;
        w = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) w[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return w;
    endfunction

    assign ready_state = (state != S_WAIT) && (state != S_ERR1);
    assign accept      = HSEL && HREADY && HTRANS[1];
    assign legal       = addr_legal(HADDR, HSIZE);
    assign unused_ok   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Address phase -> data phase control
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_DATA;
                    else             cnt   <= cnt - 4'd1;
                end
                S_ERR1: state <= S_ERR2;
                default: begin
                    if (!accept)                state <= S_IDLE;
                    else if (!legal)            state <= S_ERR1;
                    else if (WAIT_STATES == 0)  state <= S_DATA;
                    else begin
                        state <= S_WAIT;
                        cnt   <= 4'(WAIT_STATES - 1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (ready_state && accept) begin
            idx_p0   <= HADDR[IDX_W+1:2];
            lane_p0  <= HADDR[1:0];
            size_p0  <= HSIZE;
            write_p0 <= HWRITE;
        end
    end

    // Data phase: write commits on the edge that closes DATA
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && write_p0)
            mem[idx_p0] <= merge_bytes(mem[idx_p0], HWDATA, lane_mask(lane_p0, size_p0));
    end

    assign HRDATA    = (state == S_DATA) ? mem[idx_p0] : 32'h0;
    assign HREADYOUT = ready_state;
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: a zero-wait and a two-wait instance of the SRAM slave
// driven by pipelined directed and random transfers against a memory model.
module tb_ahb_lite_sram_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel0, hsel2, stall0;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] rd0, rd2;
    logic        ro0, ro2, resp0, resp2;
    logic        hready0, hready2;

    assign hready0 = ro0 & ~stall0;
    assign hready2 = ro2;

    ahb_lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready0),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready2),
        .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(resp2)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] model [2][1024];
    bit          known [2][1024];

    logic [31:0] tr_addr  [16];
    logic [31:0] tr_wdata [16];
    logic [31:0] tr_rdata [16];
    logic [2:0]  tr_size  [16];
    logic        tr_write [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size);
        if (size > 3'd2) return 1'b0;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b0;
        return (addr / 32'd4) < 32'd1024;
    endfunction

    task automatic set_tr(input int k, input logic w, input logic [31:0] a,
                          input logic [2:0] s, input logic [31:0] wd);
        tr_write[k] = w;
        tr_addr[k]  = a;
        tr_size[k]  = s;
        tr_wdata[k] = wd;
    endtask

    task automatic drive_addr(input int d, input int k, input int n);
        if (k < n) begin
            htrans = 2'b10;
            haddr  = tr_addr[k];
            hwrite = tr_write[k];
            hsize  = tr_size[k];
            hsel0  = (d == 0);
            hsel2  = (d == 1);
        end else begin
            htrans = 2'b00;
            haddr  = 32'h0;
            hwrite = 1'b0;
            hsize  = 3'd0;
            hsel0  = 1'b0;
            hsel2  = 1'b0;
        end
    endtask

    // Pipelined run of tr_*[0..n-1] on instance d (0: zero-wait, 1: two-wait).
    task automatic run_burst(input int d, input int n);
        int          waits;
        bit          done;
        bit          ok;
        int          idx;
        int          exp_waits;
        logic        ro, rs;
        logic [31:0] rd;
        @(posedge clk); #1;
        drive_addr(d, 0, n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            hwdata = tr_wdata[i];
            drive_addr(d, i + 1, n);
            ok        = is_legal(tr_addr[i], tr_size[i]);
            idx       = ok ? int'(tr_addr[i] >> 2) : 0;
            exp_waits = ok ? ((d == 0) ? 0 : 2) : 1;
            waits = 0;
            done  = 1'b0;
            for (int c = 0; c < 24 && !done; c++) begin
                @(negedge clk);
                ro = (d == 0) ? ro0 : ro2;
                rs = (d == 0) ? resp0 : resp2;
                rd = (d == 0) ? rd0 : rd2;
                if (!ro) begin
                    chk("resp_stall", rs, !ok);
                    chk("rdata_stall", rd, 32'h0);
                    waits++;
                end else begin
                    chk("resp_final", rs, !ok);
                    chk("wait_count", waits, exp_waits);
                    if (!ok) chk("rdata_err", rd, 32'h0);
                    else if (known[d][idx]) chk("rdata", rd, model[d][idx]);
                    tr_rdata[i] = rd;
                    if (ok && tr_write[i]) begin
                        for (int b = 0; b < (1 << tr_size[i]); b++) begin
                            int lane;
                            lane = int'(tr_addr[i] % 4) + b;
                            model[d][idx][lane*8 +: 8] = tr_wdata[i][lane*8 +: 8];
                        end
                        if (tr_size[i] == 3'd2) known[d][idx] = 1'b1;
                    end
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
            chk("xfer_done", done, 1'b1);
        end
    endtask

    initial begin
        int n;
        int d;
        rst = 1'b1; hsel0 = 1'b0; hsel2 = 1'b0; stall0 = 1'b0;
        haddr = '0; hwdata = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        for (int k = 0; k < 1024; k++) begin
            known[0][k] = 1'b0;
            known[1][k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_ready0", ro0, 1'b1);
            chk("reset_resp0", resp0, 1'b0);
            chk("reset_rdata0", rd0, 32'h0);
            chk("reset_ready2", ro2, 1'b1);
            chk("reset_resp2", resp2, 1'b0);
            chk("reset_rdata2", rd2, 32'h0);
        end

        // fill words 0..63 of both instances
        for (int dd = 0; dd < 2; dd++) begin
            for (int base = 0; base < 64; base += 8) begin
                for (int k = 0; k < 8; k++) set_tr(k, 1'b1, 32'((base + k) * 4), 3'd2, $urandom);
                run_burst(dd, 8);
            end
        end

        // word write then back-to-back read
        set_tr(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        set_tr(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run_burst(0, 2);
        chk("raw_deadbeef", tr_rdata[1], 32'hDEADBEEF);

        // byte and halfword merge
        set_tr(0, 1'b1, 32'h10, 3'd2, 32'h00000000);
        set_tr(1, 1'b1, 32'h11, 3'd0, 32'h0000AA00);
        set_tr(2, 1'b1, 32'h12, 3'd1, 32'h55660000);
        set_tr(3, 1'b0, 32'h10, 3'd2, 32'h0);
        run_burst(0, 4);
        chk("merge_word", tr_rdata[3], 32'h5566AA00);

        // error responses, memory untouched, next transfer taken from ERR2
        set_tr(0, 1'b1, 32'h02,   3'd2, 32'h11111111);
        set_tr(1, 1'b1, 32'h10,   3'd3, 32'h22222222);
        set_tr(2, 1'b1, 32'h1000, 3'd2, 32'h33333333);
        set_tr(3, 1'b0, 32'h10,   3'd2, 32'h0);
        set_tr(4, 1'b0, 32'h00,   3'd2, 32'h0);
        run_burst(0, 5);
        chk("err_mem_intact", tr_rdata[3], 32'h5566AA00);
        run_burst(1, 5);

        // two wait states: write then read, next NONSEQ held during waits
        set_tr(0, 1'b1, 32'h20, 3'd2, 32'h12345678);
        set_tr(1, 1'b0, 32'h20, 3'd2, 32'h0);
        set_tr(2, 1'b0, 32'h24, 3'd2, 32'h0);
        run_burst(1, 3);
        chk("ws2_read", tr_rdata[1], 32'h12345678);

        // another slave stalling: no acceptance while HREADY is low
        @(posedge clk); #1;
        stall0 = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; hsel0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_ready", ro0, 1'b1);
        chk("stall_rdata", rd0, 32'h0);
        @(posedge clk); #1;
        htrans = 2'b00; hsel0 = 1'b0; stall0 = 1'b0;
        @(negedge clk);
        chk("stall_after", rd0, 32'h0);

        // reset while a write is waiting
        @(posedge clk); #1;
        haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; hsel2 = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'hCAFEF00D; htrans = 2'b00; hsel2 = 1'b0; hwrite = 1'b0;
        @(negedge clk);
        chk("rst_in_wait", ro2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", ro2, 1'b1);
        chk("rst_mid_resp", resp2, 1'b0);
        chk("rst_mid_rdata", rd2, 32'h0);
        set_tr(0, 1'b0, 32'h20, 3'd2, 32'h0);
        run_burst(1, 1);
        chk("rst_write_dropped", tr_rdata[0], 32'h12345678);

        // random pipelined traffic
        for (int r = 0; r < 30; r++) begin
            d = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                int idx;
                int sz;
                idx = int'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0: set_tr(k, 1'($urandom_range(0, 1)), 32'(idx * 4), 3'd3, $urandom);
                        1: set_tr(k, 1'($urandom_range(0, 1)), 32'(idx * 4 + int'($urandom_range(1, 3))), 3'd2, $urandom);
                        default: set_tr(k, 1'($urandom_range(0, 1)), 32'(32'h1000 + idx * 4), 3'd2, $urandom);
                    endcase
                end else begin
                    sz = int'($urandom_range(0, 2));
                    set_tr(k, 1'($urandom_range(0, 1)),
                           32'(idx * 4 + ((sz == 0) ? int'($urandom_range(0, 3)) :
                                          (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0)),
                           3'(sz), $urandom);
                end
            end
            run_burst(d, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
